// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the chess clock display.
// The optional blink feature is selected by the CHESS_DISPLAY_BLINK_EN macro.
package chess_clock_pkg;

    localparam int DIGIT_W = 4;
    localparam int SECS_W  = 10;

    localparam logic [SECS_W-1:0]  SECS_MAX    = 10'd599;
    localparam logic [6:0]         SEG_BLANK   = 7'h7F;
    localparam logic [DIGIT_W-1:0] DIGIT_BLANK = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MIN   = 3'd2,
        ST_TENS  = 3'd3,
        ST_WRITE = 3'd4
    } state_e;

    // Saturate a raw 12-bit seconds value to the largest displayable M:SS.
    function automatic logic [SECS_W-1:0] clamp_secs(input logic [11:0] secs);
        logic [SECS_W-1:0] res;
        if (secs > 12'd599) begin
            res = SECS_MAX;
        end else begin
            res = secs[SECS_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Digit to active-low 7-segment decoder, segment order gfedcba.
// Any code outside 0-9 produces a blank digit.
module seg7_decode
    import chess_clock_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [6:0]         seg
);

    // Map each decimal digit to its lit-segment pattern.
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/chess_clock_display.sv
// Chess clock display: converts both players' remaining seconds to M:SS
// by repeated subtraction and drives six active-low 7-segment digits.
// Optional low-time blink of the active player: define CHESS_DISPLAY_BLINK_EN.
module chess_clock_display
    import chess_clock_pkg::*;
#(
    parameter int BLINK_DIV = 25000000
) (
    input  logic        st_clk,
    input  logic        rst,
    input  logic        upd,
    input  logic [11:0] p1_secs,
    input  logic [11:0] p2_secs,
    input  logic        act,
    output logic [6:0]  hex5,
    output logic [6:0]  hex4,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic        busy,
    output logic        done
);

    state_e state_q, state_d;

    logic [SECS_W-1:0]  p1_cap_q, p1_cap_d;
    logic [SECS_W-1:0]  p2_cap_q, p2_cap_d;
    logic [SECS_W-1:0]  r_q, r_d;
    logic [DIGIT_W-1:0] m_q, m_d;
    logic [DIGIT_W-1:0] t_q, t_d;
    logic               sel_q, sel_d;
    logic               done_q, done_d;

    // Index 5..3 is player 1 (M, tens, ones), 2..0 is player 2.
    logic [DIGIT_W-1:0] dig_q [6];
    logic [DIGIT_W-1:0] dig_d [6];
    logic [6:0]         seg_s [6];

    // State register.
    always_ff @(posedge st_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; upd is only looked at in IDLE, so requests never queue.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (upd) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: state_d = ST_MIN;
            ST_MIN: begin
                if (r_q >= 10'd60) begin
                    state_d = ST_MIN;
                end else begin
                    state_d = ST_TENS;
                end
            end
            ST_TENS: begin
                if (r_q >= 10'd10) begin
                    state_d = ST_TENS;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (sel_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: capture, subtract-and-count, digit write-back.
    always_comb begin
        p1_cap_d = p1_cap_q;
        p2_cap_d = p2_cap_q;
        r_d      = r_q;
        m_d      = m_q;
        t_d      = t_q;
        sel_d    = sel_q;
        done_d   = 1'b0;
        dig_d    = dig_q;
        case (state_q)
            ST_LOAD: begin
                p1_cap_d = clamp_secs(p1_secs);
                p2_cap_d = clamp_secs(p2_secs);
                r_d      = clamp_secs(p1_secs);
                m_d      = 4'd0;
                t_d      = 4'd0;
                sel_d    = 1'b0;
            end
            ST_MIN: begin
                if (r_q >= 10'd60) begin
                    r_d = r_q - 10'd60;
                    m_d = m_q + 4'd1;
                end else begin
                    r_d = r_q;
                end
            end
            ST_TENS: begin
                if (r_q >= 10'd10) begin
                    r_d = r_q - 10'd10;
                    t_d = t_q + 4'd1;
                end else begin
                    r_d = r_q;
                end
            end
            ST_WRITE: begin
                if (sel_q) begin
                    dig_d[2] = m_q;
                    dig_d[1] = t_q;
                    dig_d[0] = r_q[DIGIT_W-1:0];
                    done_d   = 1'b1;
                end else begin
                    dig_d[5] = m_q;
                    dig_d[4] = t_q;
                    dig_d[3] = r_q[DIGIT_W-1:0];
                    r_d      = p2_cap_q;
                    m_d      = 4'd0;
                    t_d      = 4'd0;
                    sel_d    = 1'b1;
                end
            end
            default: begin
                r_d = r_q;
            end
        endcase
    end

    // Datapath registers; reset blanks every digit.
    always_ff @(posedge st_clk) begin
        if (rst) begin
            p1_cap_q <= 10'd0;
            p2_cap_q <= 10'd0;
            r_q      <= 10'd0;
            m_q      <= 4'd0;
            t_q      <= 4'd0;
            sel_q    <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                dig_q[i] <= DIGIT_BLANK;
            end
        end else begin
            p1_cap_q <= p1_cap_d;
            p2_cap_q <= p2_cap_d;
            r_q      <= r_d;
            m_q      <= m_d;
            t_q      <= t_d;
            sel_q    <= sel_d;
            done_q   <= done_d;
            dig_q    <= dig_d;
        end
    end

    for (genvar g = 0; g < 6; g++) begin : g_dec
        seg7_decode u_dec (
            .digit (dig_q[g]),
            .seg   (seg_s[g])
        );
    end

`ifdef CHESS_DISPLAY_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [1:0]       low_q, low_d;
    logic             blink_off_s;

    // Free-running blink counter wrapping at BLINK_DIV-1.
    always_comb begin
        if (blink_cnt_q >= CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    // Remember, per player, whether the last written time was under 10 s.
    always_comb begin
        low_d = low_q;
        if (state_q == ST_WRITE) begin
            low_d[sel_q] = (m_q == 4'd0) && (t_q == 4'd0);
        end else begin
            low_d = low_q;
        end
    end

    // Blink counter and low-time flags.
    always_ff @(posedge st_clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            low_q       <= 2'b00;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            low_q       <= low_d;
        end
    end

    assign blink_off_s = (blink_cnt_q >= CNT_W'(BLINK_DIV / 2));
`else
    logic unused_cfg_s;
    assign unused_cfg_s = act ^ (BLINK_DIV == 0);
`endif

    // Output stage: status flags and decoded digits, with optional blanking.
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = done_q;
        hex5 = seg_s[5];
        hex4 = seg_s[4];
        hex3 = seg_s[3];
        hex2 = seg_s[2];
        hex1 = seg_s[1];
        hex0 = seg_s[0];
`ifdef CHESS_DISPLAY_BLINK_EN
        if (blink_off_s && !act && low_q[0]) begin
            hex5 = SEG_BLANK;
            hex4 = SEG_BLANK;
            hex3 = SEG_BLANK;
        end else if (blink_off_s && act && low_q[1]) begin
            hex2 = SEG_BLANK;
            hex1 = SEG_BLANK;
            hex0 = SEG_BLANK;
        end else begin
            hex0 = seg_s[0];
        end
`endif
    end

endmodule

// File: doc/chess_clock_display.md
CHESS_CLOCK_DISPLAY -- requirements
Module: chess_clock_display

Interface
REQ-001 Parameter BLINK_DIV, default 25000000, st_clk cycles per full blink period (half blanked); used only when blink is compiled in.
REQ-002 st_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 upd  input  1  one-cycle request to sample and render both player times.
REQ-005 p1_secs  input  12  player 1 remaining seconds, unsigned.
REQ-006 p2_secs  input  12  player 2 remaining seconds, unsigned.
REQ-007 act  input  1  player to move: 0 = P1, 1 = P2.
REQ-008 hex5..hex3  output  7 each  P1 as M:SS (hex5 = minutes, hex4 = tens, hex3 = ones); segment order gfedcba, active-low.
REQ-009 hex2..hex0  output  7 each  P2 as M:SS, same mapping.
REQ-010 busy  output  1  high while a conversion is in progress.
REQ-011 done  output  1  one-cycle pulse when both players' digits are updated.

Function
REQ-012 FSM states: IDLE, LOAD, MIN, TENS, WRITE; encoding in package.
REQ-013 IDLE: upd=1 -> LOAD; upd is ignored in every other state, with no queuing.
REQ-014 LOAD: capture p1_secs and p2_secs, each clamped to 599 if greater; working remainder r = P1 value; m = 0; t = 0; sel = 0; -> MIN.
REQ-015 MIN: each cycle, if r >= 60 then r -= 60 and m += 1, else -> TENS.
REQ-016 TENS: each cycle, if r >= 10 then r -= 10 and t += 1, else -> WRITE.
REQ-017 WRITE: latch m, t, r into the digit registers of player sel.
REQ-018 WRITE with sel=0: load r from the captured P2 value, clear m and t, set sel = 1, -> MIN.
REQ-019 WRITE with sel=1: pulse done for one cycle, -> IDLE.
REQ-020 Per player, MIN takes m+1 cycles, TENS takes t+1 cycles, and WRITE takes 1 cycle.
REQ-021 The edge that samples upd is edge 0; done is high for exactly the cycle after edge 1 + Σ(m+t+3) over both players.
REQ-022 busy is high in every state except IDLE.
REQ-023 Digit registers change only in WRITE; the unselected player's digits hold.
REQ-024 Outputs come from registered digits through the 7-segment decode.
REQ-025 Decode 0-9 to standard active-low patterns; any other code decodes to blank (7'h7F).
REQ-026 Input changes after LOAD do not affect the conversion in progress.

Reset
REQ-027 rst=1 at any edge, including mid-conversion: state = IDLE, busy = 0, done = 0, sel = 0, m = t = r = 0.
REQ-028 On that reset, all digit registers are set to blank so that all hex outputs = 7'h7F, and the blink counter = 0.
REQ-029 After rst deasserts, the first upd starts a full conversion normally.

Configuration
REQ-030 Macro CHESS_DISPLAY_BLINK_EN defined: a free-running counter wraps at BLINK_DIV-1.
REQ-031 With the macro, while the counter is >= BLINK_DIV/2, the three digits of player act show 7'h7F if that player's last-written value is < 10 s.
REQ-032 Macro absent: no blink counter is built; act is unused; outputs always show the decoded digits.

Structure
REQ-033 Package chess_clock_pkg holds the FSM state typedef, the constants SECS_MAX = 599, SEG_BLANK = 7'h7F, and the digit-width constant.
REQ-034 One combinational sub-module, seg7_decode (4-bit digit in, 7-bit active-low segments out), is instantiated six times.

Verification
REQ-035 Reset, then p1=125 and p2=0 with an upd pulse: hex5..3 show 2,0,5; hex2..0 show 0,0,0; done lands in the cycle after edge 9.
REQ-036 p1=599, p2=4095 with an upd pulse: both players show 9:59; done lands in the cycle after edge 1+2*(9+5+3) = 35.
REQ-037 A second upd mid-conversion is ignored; changing p1_secs after LOAD leaves the result reflecting the captured value.
REQ-038 rst asserted during MIN: at the next edge busy = 0 and all hex outputs = 7'h7F; no done pulse is issued.
REQ-039 With CHESS_DISPLAY_BLINK_EN, BLINK_DIV=4, act=1, p2=7: hex2..0 alternate 0,0,7 and blank every 2 cycles while P1 stays steady.
REQ-040 Without the macro, the same stimulus gives hex2..0 steady at 0,0,7.
